// File: rtl/ff_pkg.sv
// Shared encodings for the flip-flop / counter primitives.
//   mode_e : counter operating modes (hold, up, down, parallel load)
//   jk_e   : JK flip-flop actions, encoded as {j, k}
package ff_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DN   = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_e;

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop, asynchronous active-low reset to 0.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   j, k  : JK inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   q     : registered state
module jk_ff_cell
    import ff_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case (jk_e'({j, k}))
                JK_HOLD: q <= q;
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TGL:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_counter.sv
// Modulo-MODULUS counter built from a bank of JK flip-flop cells.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (q=0, wrap=0)
//   en    : clock enable for all mode actions (clr ignores it)
//   clr   : synchronous clear, highest synchronous priority
//   mode  : 00 hold, 01 up, 10 down, 11 parallel load
//   d     : load value (clamped to MODULUS-1)
//   q     : counter state
//   tc    : combinational terminal count (next enabled edge wraps)
//   wrap  : registered one-cycle pulse, previous edge wrapped
module jk_counter
    import ff_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    // One extra bit so range compares against MAX_Q are never constant
    // when MODULUS == 2**WIDTH.
    localparam logic [WIDTH:0]   MAX_X = {1'b0, MAX_Q};

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "jk_counter: WIDTH %0d outside 1..32", WIDTH);
    end
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_mod
        $fatal(1, "jk_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end

    mode_e            mode_s;
    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             ld;
    logic             wrap_nxt;
    logic             wrap_q;

    assign mode_s = mode_e'(mode);

    // Count steps toggle the bits that differ between q and q+-1; every
    // other change (clear, load, modulus wrap, fault recovery) drives the
    // target value straight in through J=v, K=~v.
    always_comb begin
        tgl      = '0;
        tgt      = '0;
        ld       = 1'b0;
        wrap_nxt = wrap_q;
        if (clr) begin
            ld       = 1'b1;
            wrap_nxt = 1'b0;
        end else if (en) begin
            case (mode_s)
                MODE_HOLD: begin
                    wrap_nxt = 1'b0;
                end
                MODE_UP: begin
                    if ({1'b0, q_vec} >= MAX_X) begin
                        ld       = 1'b1;
                        wrap_nxt = 1'b1;
                    end else begin
                        tgl      = q_vec ^ (q_vec + WIDTH'(1));
                        wrap_nxt = 1'b0;
                    end
                end
                MODE_DN: begin
                    if (q_vec == '0) begin
                        ld       = 1'b1;
                        tgt      = MAX_Q;
                        wrap_nxt = 1'b1;
                    end else if ({1'b0, q_vec} > MAX_X) begin
                        // Out-of-range q: q-1 is still >= MODULUS-1, clamp it.
                        ld       = 1'b1;
                        tgt      = MAX_Q;
                        wrap_nxt = 1'b0;
                    end else begin
                        tgl      = q_vec ^ (q_vec - WIDTH'(1));
                        wrap_nxt = 1'b0;
                    end
                end
                MODE_LOAD: begin
                    ld       = 1'b1;
                    tgt      = ({1'b0, d} > MAX_X) ? MAX_Q : d;
                    wrap_nxt = 1'b0;
                end
                default: begin
                    wrap_nxt = wrap_q;
                end
            endcase
        end
        j_vec = ld ? tgt  : tgl;
        k_vec = ld ? ~tgt : tgl;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j_vec[i]),
            .k     (k_vec[i]),
            .q     (q_vec[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_nxt;
        end
    end

    assign tc   = en & ~clr & (((mode_s == MODE_UP) & (q_vec == MAX_Q)) |
                               ((mode_s == MODE_DN) & (q_vec == '0)));
    assign q    = q_vec;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_counter.sv
module tb_jk_counter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       clr   = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic [7:0] d     = 8'd0;

    logic [3:0] q0, q1;
    logic       q2;
    logic [7:0] q3;
    logic       tc0, tc1, tc2, tc3;
    logic       wrap0, wrap1, wrap2, wrap3;

    jk_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .d(d[3:0]), .q(q0), .tc(tc0), .wrap(wrap0));
    jk_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .d(d[3:0]), .q(q1), .tc(tc1), .wrap(wrap1));
    jk_counter #(.WIDTH(1), .MODULUS(2)) u_m2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .d(d[0]), .q(q2), .tc(tc2), .wrap(wrap2));
    jk_counter #(.WIDTH(8), .MODULUS(256)) u_m256 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .d(d), .q(q3), .tc(tc3), .wrap(wrap3));

    always #5 clk = ~clk;

    localparam int N = 4;
    int mods  [N] = '{16, 10, 2, 256};
    int masks [N] = '{15, 15, 1, 255};
    int mq [N];
    int mw [N];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       e;
        logic       c;
        logic [1:0] m;
        logic [7:0] dv;
        int         eq;
        logic       etc;
        logic       ew;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [31:0] get_q(int i);
        case (i)
            0: return 32'(q0);
            1: return 32'(q1);
            2: return 32'(q2);
            default: return 32'(q3);
        endcase
    endfunction

    function automatic logic get_tc(int i);
        case (i)
            0: return tc0;
            1: return tc1;
            2: return tc2;
            default: return tc3;
        endcase
    endfunction

    function automatic logic get_wrap(int i);
        case (i)
            0: return wrap0;
            1: return wrap1;
            2: return wrap2;
            default: return wrap3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_tc(int i);
        return en && !clr && ((mode == 2'b01 && mq[i] == mods[i] - 1) ||
                              (mode == 2'b10 && mq[i] == 0));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i] = 0;
            mw[i] = 0;
        end
    endtask

    task automatic model_step();
        int dd;
        for (int i = 0; i < N; i++) begin
            if (!rst_n || clr) begin
                mq[i] = 0;
                mw[i] = 0;
            end else if (en) begin
                case (mode)
                    2'b00: mw[i] = 0;
                    2'b01: begin
                        mw[i] = (mq[i] == mods[i] - 1) ? 1 : 0;
                        mq[i] = (mq[i] + 1) % mods[i];
                    end
                    2'b10: begin
                        mw[i] = (mq[i] == 0) ? 1 : 0;
                        mq[i] = (mq[i] + mods[i] - 1) % mods[i];
                    end
                    default: begin
                        dd    = int'(d) & masks[i];
                        mq[i] = (dd >= mods[i]) ? mods[i] - 1 : dd;
                        mw[i] = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic check_tc_all();
        for (int i = 0; i < N; i++)
            check($sformatf("tc[%0d]", i), 32'(get_tc(i)), 32'(model_tc(i)));
    endtask

    task automatic check_state_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("q[%0d]", i), get_q(i), 32'(mq[i]));
            check($sformatf("wrap[%0d]", i), 32'(get_wrap(i)), 32'(mw[i]));
        end
    endtask

    task automatic cycle(input logic e, input logic c, input logic [1:0] m, input logic [7:0] dv);
        en   = e;
        clr  = c;
        mode = m;
        d    = dv;
        #1;
        check_tc_all();
        @(posedge clk);
        model_step();
        #1;
        check_state_all();
    endtask

    initial begin
        // e  c  m      d      q  tc  wrap   (tc before edge, q/wrap after, MOD10 instance)
        tbl[0]  = '{1'b1, 1'b0, 2'b11, 8'd13, 9, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'b11, 8'd5,  5, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'b11, 8'd2,  5, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'b11, 8'd7,  0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 2'b01, 8'd0,  0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 2'b01, 8'd0,  0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 2'b10, 8'd0,  9, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 2'b10, 8'd0,  8, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 2'b11, 8'd9,  9, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 2'b01, 8'd0,  0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 2'b01, 8'd0,  0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 2'b00, 8'd0,  0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 2'b10, 8'd0,  0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 2'b11, 8'd10, 9, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 2'b01, 8'd0,  9, 1'b0, 1'b0};

        // Reset state
        model_reset();
        #12;
        check_state_all();
        rst_n = 1'b1;

        // Table-driven vectors on the MODULUS=10 instance
        for (int r = 0; r < 15; r++) begin
            en   = tbl[r].e;
            clr  = tbl[r].c;
            mode = tbl[r].m;
            d    = tbl[r].dv;
            #1;
            check($sformatf("tbl%0d_tc", r), 32'(tc1), 32'(tbl[r].etc));
            check_tc_all();
            @(posedge clk);
            model_step();
            #1;
            check($sformatf("tbl%0d_q", r), 32'(q1), 32'(tbl[r].eq));
            check($sformatf("tbl%0d_wrap", r), 32'(wrap1), 32'(tbl[r].ew));
            check_state_all();
        end

        // Asynchronous reset mid-count, then restart from 0
        cycle(1'b1, 1'b1, 2'b00, 8'd0);
        for (int k = 0; k < 9; k++) cycle(1'b1, 1'b0, 2'b01, 8'd0);
        check("pre_rst_q", 32'(q0), 32'd9);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_q", 32'(q0), 32'd0);
        check("async_rst_wrap", 32'(wrap0), 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b1, 1'b0, 2'b01, 8'd0);
            check($sformatf("post_rst_q%0d", k), 32'(q0), 32'(k));
        end

        // Up wrap at MODULUS=10
        cycle(1'b1, 1'b1, 2'b00, 8'd0);
        for (int k = 0; k < 10; k++) begin
            en = 1'b1; clr = 1'b0; mode = 2'b01; d = 8'd0;
            #1;
            check($sformatf("upwrap_q%0d", k), 32'(q1), 32'(k));
            check($sformatf("upwrap_tc%0d", k), 32'(tc1), (k == 9) ? 32'd1 : 32'd0);
            @(posedge clk);
            model_step();
            #1;
            check_state_all();
        end
        check("upwrap_q_end", 32'(q1), 32'd0);
        check("upwrap_pulse", 32'(wrap1), 32'd1);
        cycle(1'b1, 1'b0, 2'b01, 8'd0);
        check("upwrap_pulse_end", 32'(wrap1), 32'd0);
        check("upwrap_q_next", 32'(q1), 32'd1);

        // Down wrap at MODULUS=10
        cycle(1'b1, 1'b0, 2'b11, 8'd0);
        en = 1'b1; clr = 1'b0; mode = 2'b10;
        #1;
        check("dnwrap_tc", 32'(tc1), 32'd1);
        @(posedge clk);
        model_step();
        #1;
        check("dnwrap_q", 32'(q1), 32'd9);
        check("dnwrap_wrap", 32'(wrap1), 32'd1);
        cycle(1'b1, 1'b0, 2'b10, 8'd0);
        check("dnwrap_q2", 32'(q1), 32'd8);
        check("dnwrap_wrap2", 32'(wrap1), 32'd0);

        // Full up/down sweeps (covers WIDTH=1 and WIDTH=8 fully)
        cycle(1'b1, 1'b1, 2'b00, 8'd0);
        for (int k = 0; k < 300; k++) cycle(1'b1, 1'b0, 2'b01, 8'd0);
        for (int k = 0; k < 300; k++) cycle(1'b1, 1'b0, 2'b10, 8'd0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
